// File: rtl/rv32im_pkg.sv
// Shared RV32IM front-end definitions: instruction cache states, fetch
// constants and a block word-select helper.
package rv32im_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MEMREAD,
    UPDATE
  } icache_state_t;

  localparam logic [31:0] NOP_INSTR       = 32'h00000013;
  localparam int          BLOCK_BITS      = 128;
  localparam int          WORDS_PER_BLOCK = 4;

  // Word 0 occupies the least significant 32 bits of a block.
  function automatic logic [31:0] select_word(input logic [BLOCK_BITS-1:0] blk,
                                              input logic [1:0]            off);
    return blk[{off, 5'b00000} +: 32];
  endfunction

endpackage

// File: rtl/instruction_cache_if.sv
// Fetch-side (PC) and memory-side signals of the instruction cache.
// The cache binds the slave modport; the PC/memory environment binds master.
interface instruction_cache_if;
  import rv32im_pkg::*;

  logic [31:0]           ADDRESS;
  logic [31:0]           INSTRUCTION;
  logic                  BUSYWAIT;
  logic                  MEM_READ;
  logic [27:0]           MEM_ADDRESS;
  logic [BLOCK_BITS-1:0] MEM_READDATA;
  logic                  MEM_BUSYWAIT;

  modport slave (
    input  ADDRESS, MEM_READDATA, MEM_BUSYWAIT,
    output INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
  );

  modport master (
    output ADDRESS, MEM_READDATA, MEM_BUSYWAIT,
    input  INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
  );

endinterface

// File: rtl/icache_line_array.sv
// Valid/tag/data storage for the direct-mapped instruction cache:
// combinational read port, synchronous write port, synchronous valid clear.
module icache_line_array
  import rv32im_pkg::*;
#(
  parameter int NUM_BLOCKS = 8,
  parameter int INDEX_W    = $clog2(NUM_BLOCKS),
  parameter int TAG_W      = 28 - INDEX_W
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic [INDEX_W-1:0]    rd_index,
  output logic                  rd_valid,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [BLOCK_BITS-1:0] rd_block,
  input  logic                  wr_en,
  input  logic [INDEX_W-1:0]    wr_index,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [BLOCK_BITS-1:0] wr_block
);

  logic [NUM_BLOCKS-1:0] valid;
  logic [TAG_W-1:0]      tag_mem  [NUM_BLOCKS];
  logic [BLOCK_BITS-1:0] data_mem [NUM_BLOCKS];

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_index] <= 1'b1;
    end
  end

  // Tag and data need no reset: a line is only looked at when its valid bit is set.
  always_ff @(posedge CLOCK) begin
    if (wr_en) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_block;
    end
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_block = data_mem[rd_index];

endmodule

// File: rtl/instruction_cache.sv
// Read-only direct-mapped instruction cache: same-cycle hits, miss handling
// through an IDLE -> MEMREAD -> UPDATE refill sequence that stalls the PC.
module instruction_cache
  import rv32im_pkg::*;
#(
  parameter  int NUM_BLOCKS = 8,
  localparam int INDEX_W    = $clog2(NUM_BLOCKS),
  localparam int TAG_W      = 28 - INDEX_W
) (
  input logic                 CLOCK,
  input logic                 RESET,
  instruction_cache_if.slave  bus
);

  icache_state_t         state;
  logic [27:0]           miss_blk;
  logic [BLOCK_BITS-1:0] fill_buf;
  logic                  mem_read;

  logic [INDEX_W-1:0]    addr_index;
  logic [TAG_W-1:0]      addr_tag;
  logic [1:0]            addr_word;
  logic                  addr_unused;

  logic                  line_valid;
  logic [TAG_W-1:0]      line_tag;
  logic [BLOCK_BITS-1:0] line_block;
  logic                  line_wr_en;
  logic                  hit;

  assign addr_word   = bus.ADDRESS[3:2];
  assign addr_index  = bus.ADDRESS[INDEX_W+3:4];
  assign addr_tag    = bus.ADDRESS[31:INDEX_W+4];
  assign addr_unused = ^bus.ADDRESS[1:0];

  // A fill interrupted by reset must not leave a half-valid line behind.
  assign line_wr_en = (state == UPDATE) && !RESET;

  icache_line_array #(
    .NUM_BLOCKS (NUM_BLOCKS),
    .INDEX_W    (INDEX_W),
    .TAG_W      (TAG_W)
  ) u_lines (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .rd_index (addr_index),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_block (line_block),
    .wr_en    (line_wr_en),
    .wr_index (miss_blk[INDEX_W-1:0]),
    .wr_tag   (miss_blk[27:INDEX_W]),
    .wr_block (fill_buf)
  );

  assign hit = line_valid && (line_tag == addr_tag) && (state == IDLE) && !RESET;

  assign bus.INSTRUCTION = hit ? select_word(line_block, addr_word) : NOP_INSTR;
  assign bus.BUSYWAIT    = !hit;
  assign bus.MEM_READ    = mem_read;
  assign bus.MEM_ADDRESS = miss_blk;

  // Refill sequencer; miss_blk freezes the block address so the PC may move during a fill.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state    <= IDLE;
      miss_blk <= '0;
      fill_buf <= '0;
      mem_read <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!hit) begin
            miss_blk <= bus.ADDRESS[31:4];
            mem_read <= 1'b1;
            state    <= MEMREAD;
          end
        end
        MEMREAD: begin
          if (!bus.MEM_BUSYWAIT) begin
            fill_buf <= bus.MEM_READDATA;
            mem_read <= 1'b0;
            state    <= UPDATE;
          end
        end
        UPDATE: begin
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          mem_read <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_cache.sv
// Directed bench for instruction_cache: cold miss, hits, eviction, zero-wait
// memory, address change during a fill and reset during a fill.
module tb_instruction_cache;
  import rv32im_pkg::*;

  logic CLOCK = 1'b0;
  logic RESET = 1'b1;
  int   mem_lat  = 3;
  int   busy_cnt = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  instruction_cache_if bus ();

  instruction_cache #(.NUM_BLOCKS(8)) dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLOCK = ~CLOCK;

  // Memory contents: block 0 holds the program from the test plan; every other
  // word reads back as 0x10000000 | byte address.
  function automatic logic [127:0] blk_data(input logic [27:0] blk);
    logic [127:0] d;
    if (blk == 28'd0) begin
      d = {32'h00000013, 32'h002081B3, 32'h00500113, 32'h00400093};
    end else begin
      for (int i = 0; i < 4; i++) begin
        d[i*32 +: 32] = 32'h1000_0000 | {blk, 4'b0000} | 32'(i * 4);
      end
    end
    return d;
  endfunction

  // Memory is busy for mem_lat cycles of each read request.
  always @(posedge CLOCK) begin
    if (!bus.MEM_READ) busy_cnt <= 0;
    else               busy_cnt <= busy_cnt + 1;
  end

  assign bus.MEM_BUSYWAIT = bus.MEM_READ && (busy_cnt < mem_lat);
  assign bus.MEM_READDATA = blk_data(bus.MEM_ADDRESS);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Count stalled cycles starting with the current one until BUSYWAIT drops.
  task automatic wait_ready(inout int nbusy, inout int nrd, inout logic [27:0] maddr);
    while (bus.BUSYWAIT && nbusy < 64) begin
      nbusy++;
      if (bus.MEM_READ) begin
        nrd++;
        maddr = bus.MEM_ADDRESS;
      end
      @(posedge CLOCK); #3;
    end
    if (nbusy >= 64) check("ready_timeout", 32'(nbusy), 32'd0);
  endtask

  // Called at posedge+1; presents the address and returns at posedge+3 of the ready cycle.
  task automatic fetch(input logic [31:0] a, output int nbusy, output int nrd,
                       output logic [27:0] maddr);
    bus.ADDRESS = a;
    #2;
    nbusy = 0;
    nrd   = 0;
    maddr = '0;
    wait_ready(nbusy, nrd, maddr);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int          nb, nr;
    logic [27:0] ma;
    logic [31:0] hit_addr [3];
    logic [31:0] hit_inst [3];
    hit_addr = '{32'h4, 32'h8, 32'hC};
    hit_inst = '{32'h00500113, 32'h002081B3, 32'h00000013};

    bus.ADDRESS = 32'hFFFF_FFFC;

    // Reset state
    repeat (2) @(posedge CLOCK);
    #3;
    check("rst_busywait", 32'(bus.BUSYWAIT), 32'd1);
    check("rst_instr", bus.INSTRUCTION, NOP_INSTR);
    check("rst_mem_read", 32'(bus.MEM_READ), 32'd0);
    check("rst_mem_addr", 32'(bus.MEM_ADDRESS), 32'd0);

    // Cold miss at 0x0, L=3
    @(posedge CLOCK); #1;
    RESET = 1'b0;
    fetch(32'h0, nb, nr, ma);
    check("cold_busy_cycles", 32'(nb), 32'd6);
    check("cold_memread_cycles", 32'(nr), 32'd4);
    check("cold_mem_addr", 32'(ma), 32'h0);
    check("cold_instr", bus.INSTRUCTION, 32'h00400093);

    // Hit sweep
    for (int i = 0; i < 3; i++) begin
      @(posedge CLOCK); #1;
      fetch(hit_addr[i], nb, nr, ma);
      check("hit_busy", 32'(nb), 32'd0);
      check("hit_instr", bus.INSTRUCTION, hit_inst[i]);
      check("hit_mem_read", 32'(bus.MEM_READ), 32'd0);
    end

    // Conflict eviction 0x080 vs 0x000
    @(posedge CLOCK); #1;
    fetch(32'h80, nb, nr, ma);
    check("evict_a_busy", 32'(nb), 32'd6);
    check("evict_a_mem_addr", 32'(ma), 32'h8);
    check("evict_a_instr", bus.INSTRUCTION, 32'h10000080);
    @(posedge CLOCK); #1;
    fetch(32'h0, nb, nr, ma);
    check("evict_b_busy", 32'(nb), 32'd6);
    check("evict_b_mem_addr", 32'(ma), 32'h0);
    check("evict_b_instr", bus.INSTRUCTION, 32'h00400093);

    // Zero-wait memory at 0x10
    mem_lat = 0;
    @(posedge CLOCK); #1;
    fetch(32'h10, nb, nr, ma);
    check("zw_busy_cycles", 32'(nb), 32'd3);
    check("zw_memread_cycles", 32'(nr), 32'd1);
    check("zw_mem_addr", 32'(ma), 32'h1);
    check("zw_instr", bus.INSTRUCTION, 32'h10000010);

    // Address moves to 0x44 while 0x20 is being fetched
    mem_lat = 3;
    @(posedge CLOCK); #1;
    bus.ADDRESS = 32'h20;
    #2;
    check("mid_detect_busy", 32'(bus.BUSYWAIT), 32'd1);
    @(posedge CLOCK); #1;
    bus.ADDRESS = 32'h44;
    #2;
    check("mid_mem_read", 32'(bus.MEM_READ), 32'd1);
    check("mid_mem_addr_first", 32'(bus.MEM_ADDRESS), 32'h2);
    nb = 1;
    nr = 0;
    ma = '0;
    wait_ready(nb, nr, ma);
    check("mid_total_busy", 32'(nb), 32'd12);
    check("mid_memread_cycles", 32'(nr), 32'd8);
    check("mid_mem_addr_second", 32'(ma), 32'h4);
    check("mid_instr_44", bus.INSTRUCTION, 32'h10000044);
    @(posedge CLOCK); #1;
    fetch(32'h20, nb, nr, ma);
    check("mid_line2_busy", 32'(nb), 32'd0);
    check("mid_line2_instr", bus.INSTRUCTION, 32'h10000020);

    // Reset in the second MEMREAD cycle of a miss at 0x30
    @(posedge CLOCK); #1;
    bus.ADDRESS = 32'h30;
    #2;
    check("rmf_detect_busy", 32'(bus.BUSYWAIT), 32'd1);
    @(posedge CLOCK); #3;
    check("rmf_mem_read_1", 32'(bus.MEM_READ), 32'd1);
    @(posedge CLOCK); #1;
    RESET = 1'b1;
    #2;
    check("rmf_busy_in_reset", 32'(bus.BUSYWAIT), 32'd1);
    check("rmf_instr_in_reset", bus.INSTRUCTION, NOP_INSTR);
    @(posedge CLOCK); #1;
    #2;
    check("rmf_mem_read_dropped", 32'(bus.MEM_READ), 32'd0);
    check("rmf_mem_addr_cleared", 32'(bus.MEM_ADDRESS), 32'd0);
    @(posedge CLOCK); #1;
    RESET = 1'b0;
    fetch(32'h30, nb, nr, ma);
    check("rmf_refetch_busy", 32'(nb), 32'd6);
    check("rmf_refetch_mem_addr", 32'(ma), 32'h3);
    check("rmf_refetch_instr", bus.INSTRUCTION, 32'h10000030);
    @(posedge CLOCK); #1;
    fetch(32'h20, nb, nr, ma);
    check("rmf_line2_invalid", 32'(nb), 32'd6);
    check("rmf_line2_instr", bus.INSTRUCTION, 32'h10000020);
    @(posedge CLOCK); #1;
    fetch(32'h4, nb, nr, ma);
    check("rmf_line0_invalid", 32'(nb), 32'd6);
    check("rmf_line0_instr", bus.INSTRUCTION, 32'h00500113);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
